// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV64 size codes, FSM states and
// size helpers used by the request decoder and the store merge.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP
  } lsu_state_t;

  // Access size in bytes; the reserved code 111 maps to 8 but is faulted at accept.
  function automatic logic [3:0] f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [63:0] size_mask(input logic [3:0] size);
    case (size)
      4'd1:    return 64'h0000_0000_0000_00ff;
      4'd2:    return 64'h0000_0000_0000_ffff;
      4'd4:    return 64'h0000_0000_ffff_ffff;
      default: return 64'hffff_ffff_ffff_ffff;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed bytes of a doubleword and sign/zero-extends them
// to 64 bits.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [63:0] dword,
  input  logic [2:0]  off,
  input  logic [3:0]  size,
  input  logic        sign,
  output logic [63:0] data
);

  logic [63:0] shifted;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned; a missed case arm would otherwise infer a latch.
  always_comb begin
    shifted = dword >> {off, 3'b000};
    data    = shifted;
    case (size)
      4'd1:    data = sign ? {{56{shifted[7]}},  shifted[7:0]}  : {56'd0, shifted[7:0]};
      4'd2:    data = sign ? {{48{shifted[15]}}, shifted[15:0]} : {48'd0, shifted[15:0]};
      4'd4:    data = sign ? {{32{shifted[31]}}, shifted[31:0]} : {32'd0, shifted[31:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator for a doubleword-wide data memory;
// sub-word stores are done as read-modify-write of the enclosing doubleword.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_fault,
  output logic [63:0] Mem_Addr,
  output logic [63:0] Write_Data,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [63:0] Read_Data
);

  lsu_state_t  state;
  logic [2:0]  off_q;
  logic [3:0]  size_q;
  logic        sign_q;
  logic        write_q;
  logic [63:0] wdata_q;
  logic        mem_read_q;
  logic        mem_write_q;

  logic [3:0]  req_size;
  logic        req_sign;
  logic        req_fault;
  logic [63:0] load_data;
  logic [63:0] lane_mask;
  logic [63:0] merged;

  // Strobes are gated by reset so an aborted WRITE never reaches memory.
  assign MemRead   = mem_read_q  & ~reset;
  assign MemWrite  = mem_write_q & ~reset;
  assign req_ready = (state == S_IDLE) & ~reset;

  always_comb begin
    req_size  = f3_size(req_funct3);
    req_sign  = ~req_funct3[2] & (req_funct3 != F3_D);
    req_fault = (({1'b0, req_addr[2:0]} & (req_size - 4'd1)) != 4'd0)
              | (req_addr >= 64'(MEM_BYTES))
              | (req_funct3 == 3'b111)
              | (req_write & req_funct3[2]);
  end

  always_comb begin
    lane_mask = size_mask(size_q) << {off_q, 3'b000};
    merged    = (Read_Data & ~lane_mask)
              | ((wdata_q & size_mask(size_q)) << {off_q, 3'b000});
  end

  lsu_load_align u_load_align (
    .dword (Read_Data),
    .off   (off_q),
    .size  (size_q),
    .sign  (sign_q),
    .data  (load_data)
  );

  // NOTE: all state here uses non-blocking assignments so every register sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      off_q       <= '0;
      size_q      <= '0;
      sign_q      <= 1'b0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      Mem_Addr    <= '0;
      Write_Data  <= '0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_fault  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            off_q   <= req_addr[2:0];
            size_q  <= req_size;
            sign_q  <= req_sign;
            write_q <= req_write;
            wdata_q <= req_wdata;
            if (req_fault) begin
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_rdata <= '0;
              state      <= S_RESP;
            end else if (req_write && req_size == 4'd8) begin
              Mem_Addr    <= {req_addr[63:3], 3'b000};
              Write_Data  <= req_wdata;
              mem_write_q <= 1'b1;
              state       <= S_WRITE;
            end else begin
              Mem_Addr   <= {req_addr[63:3], 3'b000};
              mem_read_q <= 1'b1;
              state      <= S_READ;
            end
          end
        end
        S_READ: begin
          mem_read_q <= 1'b0;
          if (write_q) begin
            Write_Data  <= merged;
            mem_write_q <= 1'b1;
            state       <= S_WRITE;
          end else begin
            resp_valid <= 1'b1;
            resp_fault <= 1'b0;
            resp_rdata <= load_data;
            state      <= S_RESP;
          end
        end
        S_WRITE: begin
          mem_write_q <= 1'b0;
          resp_valid  <= 1'b1;
          resp_fault  <= 1'b0;
          resp_rdata  <= '0;
          state       <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            resp_rdata <= '0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural doubleword memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_fault;
  logic [63:0] Mem_Addr;
  logic [63:0] Write_Data;
  logic        MemWrite;
  logic        MemRead;
  logic [63:0] Read_Data;

  int total = 0;
  int bad   = 0;

  logic [63:0] mem [0:7];
  logic        mem_init;

  typedef struct {
    logic [63:0] rdata;
    logic        fault;
    int          resp_cyc;
    int          rd_cyc;
    int          wr_cyc;
    int          n_rd;
    int          n_wr;
    int          n_both;
    logic [63:0] rd_addr;
    logic [63:0] wr_addr;
    logic [63:0] wr_data;
  } op_t;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .Mem_Addr   (Mem_Addr),
    .Write_Data (Write_Data),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .Read_Data  (Read_Data)
  );

  assign Read_Data = (Mem_Addr < 64'd64) ? mem[Mem_Addr[5:3]] : 64'd0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 8; i++) mem[i] <= 64'd0;
      mem[0] <= 64'h7;
      mem[1] <= 64'h15;
      mem[7] <= 64'h6;
    end else if (MemWrite) begin
      mem[Mem_Addr[5:3]] <= Write_Data;
    end
  end

  // Issues one request with resp_ready high and traces memory activity per cycle
  // (cycle 0 = accept edge) until the response handshake.
  task automatic run_op(input logic w, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wd, output op_t r);
    r = '{rdata: 64'hx, fault: 1'bx, resp_cyc: -1, rd_cyc: -1, wr_cyc: -1,
          n_rd: 0, n_wr: 0, n_both: 0, rd_addr: 64'hx, wr_addr: 64'hx, wr_data: 64'hx};
    req_write  = w;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (MemRead && MemWrite) r.n_both++;
      if (MemRead) begin
        r.n_rd++;
        if (r.rd_cyc < 0) begin r.rd_cyc = c; r.rd_addr = Mem_Addr; end
      end
      if (MemWrite) begin
        r.n_wr++;
        if (r.wr_cyc < 0) begin r.wr_cyc = c; r.wr_addr = Mem_Addr; r.wr_data = Write_Data; end
      end
      if (resp_valid) begin
        r.resp_cyc = c;
        r.rdata    = resp_rdata;
        r.fault    = resp_fault;
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
    total++; if ({MemRead, MemWrite} !== 2'b00) begin bad++; $display("FAIL rst_strobes got=%b exp=00", {MemRead, MemWrite}); end
    total++; if ({resp_valid, resp_fault} !== 2'b00) begin bad++; $display("FAIL rst_resp got=%b exp=00", {resp_valid, resp_fault}); end
    total++; if (resp_rdata !== 64'd0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", resp_rdata); end
    total++; if ({Mem_Addr, Write_Data} !== 128'd0) begin bad++; $display("FAIL rst_mem_bus got=%h/%h exp=0/0", Mem_Addr, Write_Data); end
    @(posedge clk);
    #1;
    reset    = 1'b0;
    mem_init = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", req_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_dword();
    op_t r;
    run_op(1'b0, 3'b011, 64'd8, 64'd0, r);
    total++; if (r.rd_cyc !== 1) begin bad++; $display("FAIL ld8_read_cycle got=%0d exp=1", r.rd_cyc); end
    total++; if (r.rd_addr !== 64'd8) begin bad++; $display("FAIL ld8_mem_addr got=%h exp=8", r.rd_addr); end
    total++; if (r.resp_cyc !== 2) begin bad++; $display("FAIL ld8_resp_cycle got=%0d exp=2", r.resp_cyc); end
    total++; if (r.rdata !== 64'h15) begin bad++; $display("FAIL ld8_rdata got=%h exp=15", r.rdata); end
    total++; if (r.fault !== 1'b0) begin bad++; $display("FAIL ld8_fault got=%b exp=0", r.fault); end
    total++; if ({r.n_rd, r.n_wr} !== {32'd1, 32'd0}) begin bad++; $display("FAIL ld8_pulses got=rd%0d/wr%0d exp=rd1/wr0", r.n_rd, r.n_wr); end
  endtask

  task automatic test_store_byte();
    op_t r;
    run_op(1'b1, 3'b000, 64'd3, 64'hAAAA_AAAA_AAAA_AAFF, r);
    total++; if (r.rd_cyc !== 1) begin bad++; $display("FAIL sb_read_cycle got=%0d exp=1", r.rd_cyc); end
    total++; if (r.wr_cyc !== 2) begin bad++; $display("FAIL sb_write_cycle got=%0d exp=2", r.wr_cyc); end
    total++; if (r.wr_addr !== 64'd0) begin bad++; $display("FAIL sb_write_addr got=%h exp=0", r.wr_addr); end
    total++; if (r.wr_data !== 64'h0000_0000_FF00_0007) begin bad++; $display("FAIL sb_write_data got=%h exp=00000000ff000007", r.wr_data); end
    total++; if (r.resp_cyc !== 3) begin bad++; $display("FAIL sb_resp_cycle got=%0d exp=3", r.resp_cyc); end
    total++; if ({r.n_rd, r.n_wr, r.n_both} !== {32'd1, 32'd1, 32'd0}) begin bad++; $display("FAIL sb_pulses got=rd%0d/wr%0d/both%0d exp=1/1/0", r.n_rd, r.n_wr, r.n_both); end
    total++; if ({r.fault, r.rdata} !== 65'd0) begin bad++; $display("FAIL sb_resp got=%b/%h exp=0/0", r.fault, r.rdata); end
  endtask

  task automatic test_load_extend();
    op_t r;
    logic [2:0]  f3  [0:5] = '{3'b011, 3'b000, 3'b100, 3'b101, 3'b001, 3'b010};
    logic [63:0] adr [0:5] = '{64'd0, 64'd3, 64'd3, 64'd2, 64'd2, 64'd0};
    logic [63:0] exp [0:5] = '{64'h0000_0000_FF00_0007, 64'hFFFF_FFFF_FFFF_FFFF,
                               64'h0000_0000_0000_00FF, 64'h0000_0000_0000_FF00,
                               64'hFFFF_FFFF_FFFF_FF00, 64'hFFFF_FFFF_FF00_0007};
    for (int i = 0; i < 6; i++) begin
      run_op(1'b0, f3[i], adr[i], 64'd0, r);
      total++; if (r.rdata !== exp[i] || r.fault !== 1'b0 || r.resp_cyc !== 2) begin
        bad++; $display("FAIL load_ext[%0d] f3=%b addr=%0d got=%h/f%b/c%0d exp=%h/f0/c2", i, f3[i], adr[i], r.rdata, r.fault, r.resp_cyc, exp[i]);
      end
    end
  endtask

  task automatic test_store_dword();
    op_t r;
    run_op(1'b1, 3'b011, 64'd16, 64'hDEAD_BEEF_0123_4567, r);
    total++; if ({r.n_rd, r.wr_cyc, r.resp_cyc} !== {32'd0, 32'd1, 32'd2}) begin bad++; $display("FAIL sd_timing got=rd%0d/wr_c%0d/resp_c%0d exp=0/1/2", r.n_rd, r.wr_cyc, r.resp_cyc); end
    total++; if (r.wr_addr !== 64'd16 || r.wr_data !== 64'hDEAD_BEEF_0123_4567) begin bad++; $display("FAIL sd_bus got=%h/%h exp=10/deadbeef01234567", r.wr_addr, r.wr_data); end
    run_op(1'b0, 3'b110, 64'd20, 64'd0, r);
    total++; if (r.rdata !== 64'h0000_0000_DEAD_BEEF) begin bad++; $display("FAIL sd_lwu_back got=%h exp=00000000deadbeef", r.rdata); end
  endtask

  task automatic test_faults();
    op_t r;
    logic        w   [0:2] = '{1'b0, 1'b0, 1'b1};
    logic [2:0]  f3  [0:2] = '{3'b010, 3'b011, 3'b100};
    logic [63:0] adr [0:2] = '{64'd2, 64'd64, 64'd0};
    for (int i = 0; i < 3; i++) begin
      run_op(w[i], f3[i], adr[i], 64'h55, r);
      total++; if (r.resp_cyc !== 1 || r.fault !== 1'b1 || r.rdata !== 64'd0) begin
        bad++; $display("FAIL fault[%0d] resp got=c%0d/f%b/%h exp=c1/f1/0", i, r.resp_cyc, r.fault, r.rdata);
      end
      total++; if (r.n_rd !== 0 || r.n_wr !== 0) begin
        bad++; $display("FAIL fault[%0d] mem_access got=rd%0d/wr%0d exp=0/0", i, r.n_rd, r.n_wr);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    op_t r;
    req_write  = 1'b1;
    req_funct3 = 3'b011;
    req_addr   = 64'd56;
    req_wdata  = 64'h1234;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset     = 1'b1;
    #1;
    total++; if (MemWrite !== 1'b0) begin bad++; $display("FAIL rstw_memwrite got=%b exp=0", MemWrite); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin bad++; $display("FAIL rstw_after got=ready%b/valid%b exp=1/0", req_ready, resp_valid); end
    run_op(1'b0, 3'b011, 64'd56, 64'd0, r);
    total++; if (r.rdata !== 64'h6) begin bad++; $display("FAIL rstw_ld56 got=%h exp=6", r.rdata); end
  endtask

  task automatic test_backpressure();
    resp_ready = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b011;
    req_addr   = 64'd0;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      total++; if (resp_valid !== 1'b1 || resp_rdata !== 64'h0000_0000_FF00_0007 || req_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold[%0d] got=v%b/%h/rdy%b exp=v1/00000000ff000007/rdy0", i, resp_valid, resp_rdata, req_ready);
      end
      @(posedge clk);
      #1;
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=v%b/rdy%b exp=v0/rdy1", resp_valid, req_ready); end
  endtask

  initial begin
    reset      = 1'b1;
    mem_init   = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 64'd0;
    req_wdata  = 64'd0;
    resp_ready = 1'b1;
    test_reset();
    test_load_dword();
    test_store_byte();
    test_load_extend();
    test_store_dword();
    test_faults();
    test_reset_mid_write();
    test_backpressure();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the 64-bit data-memory interface. Accepts one load or store request at a time from the core and applies size, alignment and range checks. Drives `data_memory` through its `Mem_Addr`/`Write_Data`/`MemWrite`/`MemRead`/`Read_Data` port set and returns sign- or zero-extended load data. Byte, half and word stores become read-modify-write of the enclosing doubleword, because `data_memory` writes only full 8-byte little-endian doublewords.

## Interface
- `MEM_BYTES`, 64: memory size in bytes; multiple of 8.
- `clk` input 1: single clock; everything samples on posedge.
- `reset` input 1: synchronous, active-high.
- `req_valid` input 1: core request valid.
- `req_ready` output 1: LSU can accept; high only in IDLE.
- `req_write` input 1: 1 = store, 0 = load.
- `req_funct3` input 3: RV64 size code. 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu.
- `req_addr` input 64: byte address.
- `req_wdata` input 64: store data, low bytes used.
- `resp_valid` output 1: response valid.
- `resp_ready` input 1: core accepts response.
- `resp_rdata` output 64: extended load data; 0 for stores and faults.
- `resp_fault` output 1: access rejected, memory untouched.
- `Mem_Addr` output 64: doubleword-aligned base address to memory.
- `Write_Data` output 64: merged doubleword to memory.
- `MemWrite` output 1: memory write strobe.
- `MemRead` output 1: memory read enable.
- `Read_Data` input 64: combinational read data from memory.

## Operation
- States: IDLE, READ, WRITE, RESP.
- Handshake: a request is accepted on a cycle where `req_valid & req_ready`. At that edge the LSU registers:
  - base = `req_addr & ~7`
  - off = `req_addr[2:0]`
  - size: 1, 2, 4 or 8 bytes
  - sign flag
  - write flag
  - wdata
- Fault conditions, checked at accept:
  - misalignment: `off` not a multiple of size;
  - `req_addr >= MEM_BYTES`;
  - invalid code: funct3 = 111, or a store with funct3[2] = 1.
- On fault: go directly to RESP with `resp_fault` = 1 and `resp_rdata` = 0. No MemRead or MemWrite is issued.
- Load: IDLE→READ→RESP.
  - READ asserts `MemRead`; `Mem_Addr` = base.
  - At the end of READ, capture `Read_Data` bytes [off .. off+size-1].
  - Extend to 64 bits: sign-extend for b/h/w, zero-extend for bu/hu/wu/d.
- Doubleword store: IDLE→WRITE→RESP. `Write_Data` = wdata.
- Sub-word store: IDLE→READ→WRITE→RESP.
  - READ captures `Read_Data` and replaces bytes [off .. off+size-1] with wdata[8·size-1:0].
  - WRITE drives the merged doubleword.
- WRITE asserts `MemWrite` for exactly one cycle with `Mem_Addr` = base. Memory commits at that cycle's closing edge.
- RESP holds `resp_valid` and `resp_rdata`/`resp_fault` stable until `resp_ready`, then returns to IDLE. The next request cannot be accepted before the cycle after the response handshake.
- `MemRead` and `MemWrite` are never high together. Both are combinationally forced low while `reset` = 1.

## Timing
- Accept edge = cycle 0.
- Load: READ in cycle 1; `resp_valid` from cycle 2.
- Doubleword store: WRITE in cycle 1; `resp_valid` from cycle 2.
- Sub-word store: READ in cycle 1, WRITE in cycle 2; `resp_valid` from cycle 3.
- Fault: `resp_valid` from cycle 1.
- Reset values:
  - state IDLE, `req_ready` 1 (while reset is low);
  - `resp_valid` 0, `resp_rdata` 0, `resp_fault` 0;
  - `Mem_Addr` 0, `Write_Data` 0;
  - `MemWrite` 0, `MemRead` 0.
- `req_ready` is 0 while `reset` is high.
- Reset mid-operation aborts the operation; no write is issued. A reset during WRITE leaves memory unchanged.
- `resp_valid` held with `resp_ready` low: state stays RESP and `req_ready` stays 0 indefinitely.

## Structure
- Package `lsu_pkg` holds:
  - funct3 localparams (`F3_B` … `F3_WU`);
  - state enum;
  - function mapping funct3 to size in bytes.
- Sub-module `lsu_load_align`: combinational byte extract and sign/zero extension from (doubleword, off, size, sign). Instantiated once.
- The store merge is inline in the top-level.

## Test plan
Memory is preloaded with doubleword 0x7 at 0, 0x15 at 8 and 0x6 at 56.
- ld at 8 → `MemRead` in cycle 1 with `Mem_Addr` = 8; resp at cycle 2 with rdata = 0x15, fault = 0.
- sb 0xFF at 3, then ld at 0:
  - sb: READ in cycle 1, `MemWrite` in cycle 2 with `Write_Data` = 0x00000000FF000007; resp at cycle 3;
  - ld returns 0x00000000FF000007.
- Following that store:
  - lb at 3 → 0xFFFFFFFFFFFFFFFF;
  - lbu at 3 → 0xFF;
  - lhu at 2 → 0xFF00.
- Faults, each with resp at cycle 1, fault = 1, no `MemRead`/`MemWrite` pulse:
  - lw at 2;
  - ld at 64;
  - store with funct3 = 100.
- sd 0x1234 at 56 with `reset` pulsed high during WRITE → `MemWrite` stays 0; a later ld at 56 returns 0x6; after reset, `req_ready` = 1.
- ld at 0 with `resp_ready` low for 5 cycles → `resp_valid` and rdata stay stable, `req_ready` = 0; the handshake completes on the cycle `resp_ready` rises.
